// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK demodulator back end: combiner FSM state
// encoding and the default serial bit hold length.
package qpsk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_I = 2'd1,
    SEND_Q = 2'd2
  } state_t;

  localparam int SAMPLE_DEFAULT = 100;

endpackage

// File: rtl/qpsk_iq_comb.sv
// I/Q parallel-to-serial combiner. Each strobed I/Q pair is emitted as I
// then Q, each bit held SAMPLE clocks, with a one-clock sync_flag_o pulse
// on the first cycle of every serial bit. A new strobe always restarts the
// sequence at SEND_I, even mid-symbol or on a terminal count.
// Optional build macro QPSK_IQ_COMB_BUSY_EN adds the registered busy_o
// output (high while in SEND_I or SEND_Q).
//
// state  | meaning
// IDLE   | no symbol pending, demo_ser_o holds its last value
// SEND_I | latched I bit being driven, cnt 0..SAMPLE-1
// SEND_Q | latched Q bit being driven, cnt 0..SAMPLE-1
module qpsk_iq_comb
  import qpsk_pkg::*;
#(
  parameter int SAMPLE = SAMPLE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_I,
  input  logic sync_Q,
  input  logic sync_flag_i,
  output logic demo_ser_o,
  output logic sync_flag_o
`ifdef QPSK_IQ_COMB_BUSY_EN
  ,
  output logic busy_o
`endif
);

  localparam int CW = $clog2(SAMPLE + 1);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE - 1);

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            lat_i, lat_q, lat_i_n, lat_q_n;
  logic            ser_n, flag_n;

  // State, counter, latched pair and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_i       <= 1'b0;
      lat_q       <= 1'b0;
      demo_ser_o  <= 1'b0;
      sync_flag_o <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      lat_i       <= lat_i_n;
      lat_q       <= lat_q_n;
      demo_ser_o  <= ser_n;
      sync_flag_o <= flag_n;
    end
  end

  // Next-state and next-output decode; a strobe overrides every terminal event.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lat_i_n = lat_i;
    lat_q_n = lat_q;
    ser_n   = demo_ser_o;
    flag_n  = 1'b0;
    if (sync_flag_i) begin
      lat_i_n = sync_I;
      lat_q_n = sync_Q;
      state_n = SEND_I;
      cnt_n   = '0;
      ser_n   = sync_I;
      flag_n  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt_n = '0;
        end
        SEND_I: begin
          if (cnt == LAST) begin
            state_n = SEND_Q;
            cnt_n   = '0;
            ser_n   = lat_q;
            flag_n  = 1'b1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        SEND_Q: begin
          if (cnt == LAST) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

`ifdef QPSK_IQ_COMB_BUSY_EN
  // Busy flag registered from the next state so it aligns with the serial bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_o <= 1'b0;
    else     busy_o <= (state_n != IDLE);
  end
`endif

endmodule

// File: tb/tb_qpsk_iq_comb.sv
`timescale 1ns/1ps
// Scoreboard bench for qpsk_iq_comb (SAMPLE=100, 2 us clock). Expected
// per-cycle outputs are queued when a strobe is driven and popped on each
// falling edge.
module tb_qpsk_iq_comb;

  localparam int SAMPLE = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sync_I = 1'b0;
  logic sync_Q = 1'b0;
  logic sync_flag_i = 1'b0;
  logic demo_ser_o;
  logic sync_flag_o;
`ifdef QPSK_IQ_COMB_BUSY_EN
  logic busy_o;
`endif

  typedef struct packed {
    logic ser;
    logic flag;
    logic busy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #1000 clk = ~clk;

  qpsk_iq_comb #(.SAMPLE(SAMPLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .sync_I      (sync_I),
    .sync_Q      (sync_Q),
    .sync_flag_i (sync_flag_i),
    .demo_ser_o  (demo_ser_o),
    .sync_flag_o (sync_flag_o)
`ifdef QPSK_IQ_COMB_BUSY_EN
    ,
    .busy_o      (busy_o)
`endif
  );

  // Expected outputs for clk 1..len after a strobe carrying (i, q).
  task automatic push_symbol(input logic i, input logic q, input int len);
    exp_t e;
    for (int c = 1; c <= len; c++) begin
      e.ser  = (c <= SAMPLE) ? i : q;
      e.flag = (c == 1) || (c == SAMPLE + 1);
      e.busy = (c <= 2 * SAMPLE);
      sb.push_back(e);
    end
  endtask

  task automatic push_quiet(input logic ser, input int len);
    exp_t e;
    for (int c = 1; c <= len; c++) begin
      e.ser  = ser;
      e.flag = 1'b0;
      e.busy = 1'b0;
      sb.push_back(e);
    end
  endtask

  task automatic strobe(input logic i, input logic q);
    sync_I      = i;
    sync_Q      = q;
    sync_flag_i = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      sync_I      = 1'($urandom);
      sync_Q      = 1'($urandom);
      sync_flag_i = 1'($urandom);
      checks++;
      if (demo_ser_o !== 1'b0 || sync_flag_o !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc%0d ser=%b flag=%b required 0 0", k, demo_ser_o, sync_flag_o);
      end
`ifdef QPSK_IQ_COMB_BUSY_EN
      checks++;
      if (busy_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy cyc%0d busy=%b required 0", k, busy_o);
      end
`endif
    end
    sync_flag_i = 1'b0;
    rst = 1'b0;
    push_quiet(1'b0, 10);
    for (int k = 1; k <= 10; k++) begin
      exp_t e;
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (demo_ser_o !== e.ser || sync_flag_o !== e.flag) begin
        errors++;
        $display("FAIL post_reset cyc%0d ser=%b flag=%b required %b %b", k, demo_ser_o, sync_flag_o, e.ser, e.flag);
      end
    end
  endtask

  task automatic test_single();
    push_symbol(1'b1, 1'b0, 222);
    strobe(1'b1, 1'b0);
    for (int k = 1; k <= 222; k++) begin
      exp_t e;
      @(negedge clk);
      if (k == 1) begin
        sync_flag_i = 1'b0;
        sync_I = 1'($urandom);
        sync_Q = 1'($urandom);
      end
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL single_sb_empty cyc%0d got data required queued entry", k);
      end else begin
        e = sb.pop_front();
        checks++;
        if (demo_ser_o !== e.ser || sync_flag_o !== e.flag) begin
          errors++;
          $display("FAIL single clk%0d ser=%b flag=%b required %b %b", k, demo_ser_o, sync_flag_o, e.ser, e.flag);
        end
`ifdef QPSK_IQ_COMB_BUSY_EN
        checks++;
        if (busy_o !== e.busy) begin
          errors++;
          $display("FAIL single_busy clk%0d busy=%b required %b", k, busy_o, e.busy);
        end
`endif
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] iv, qv;
    int pulses = 0;
    iv = {3'($urandom), 2'b11};
    qv = {3'($urandom), 2'b00};
    for (int s = 0; s < 5; s++) begin
      push_symbol(iv[s], qv[s], 222);
      strobe(iv[s], qv[s]);
      for (int k = 1; k <= 222; k++) begin
        exp_t e;
        @(negedge clk);
        if (k == 1) begin
          sync_flag_i = 1'b0;
          sync_I = 1'($urandom);
          sync_Q = 1'($urandom);
        end
        if (sync_flag_o === 1'b1) pulses++;
        e = sb.pop_front();
        checks++;
        if (demo_ser_o !== e.ser || sync_flag_o !== e.flag) begin
          errors++;
          $display("FAIL stream sym%0d clk%0d ser=%b flag=%b required %b %b", s, k, demo_ser_o, sync_flag_o, e.ser, e.flag);
        end
`ifdef QPSK_IQ_COMB_BUSY_EN
        checks++;
        if (busy_o !== e.busy) begin
          errors++;
          $display("FAIL stream_busy sym%0d clk%0d busy=%b required %b", s, k, busy_o, e.busy);
        end
`endif
      end
    end
    checks++;
    if (pulses != 10) begin
      errors++;
      $display("FAIL stream_pulses count=%0d required 10", pulses);
    end
  endtask

  task automatic test_abort();
    push_symbol(1'b0, 1'b1, 150);
    push_symbol(1'b1, 1'b1, 222);
    strobe(1'b0, 1'b1);
    for (int k = 1; k <= 372; k++) begin
      exp_t e;
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (demo_ser_o !== e.ser || sync_flag_o !== e.flag) begin
        errors++;
        $display("FAIL abort clk%0d ser=%b flag=%b required %b %b", k, demo_ser_o, sync_flag_o, e.ser, e.flag);
      end
`ifdef QPSK_IQ_COMB_BUSY_EN
      checks++;
      if (busy_o !== e.busy) begin
        errors++;
        $display("FAIL abort_busy clk%0d busy=%b required %b", k, busy_o, e.busy);
      end
`endif
      if (k == 150) strobe(1'b1, 1'b1);
      else begin
        sync_flag_i = 1'b0;
        sync_I = 1'($urandom);
        sync_Q = 1'($urandom);
      end
    end
  endtask

  task automatic test_reset_mid();
    push_symbol(1'b1, 1'($urandom), 50);
    strobe(1'b1, sb[sb.size()-1].ser);
    for (int k = 1; k <= 50; k++) begin
      exp_t e;
      @(negedge clk);
      if (k == 1) sync_flag_i = 1'b0;
      e = sb.pop_front();
      checks++;
      if (demo_ser_o !== e.ser || sync_flag_o !== e.flag) begin
        errors++;
        $display("FAIL mid_pre clk%0d ser=%b flag=%b required %b %b", k, demo_ser_o, sync_flag_o, e.ser, e.flag);
      end
    end
    #100 rst = 1'b1;
    #1;
    checks++;
    if (demo_ser_o !== 1'b0 || sync_flag_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_async ser=%b flag=%b required 0 0", demo_ser_o, sync_flag_o);
    end
`ifdef QPSK_IQ_COMB_BUSY_EN
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_busy busy=%b required 0", busy_o);
    end
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_quiet(1'b0, 300);
    for (int k = 1; k <= 300; k++) begin
      exp_t e;
      @(negedge clk);
      sync_I = 1'($urandom);
      sync_Q = 1'($urandom);
      e = sb.pop_front();
      checks++;
      if (demo_ser_o !== e.ser || sync_flag_o !== e.flag) begin
        errors++;
        $display("FAIL mid_post cyc%0d ser=%b flag=%b required %b %b", k, demo_ser_o, sync_flag_o, e.ser, e.flag);
      end
`ifdef QPSK_IQ_COMB_BUSY_EN
      checks++;
      if (busy_o !== e.busy) begin
        errors++;
        $display("FAIL mid_post_busy cyc%0d busy=%b required %b", k, busy_o, e.busy);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover size=%0d required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
